// File: rtl/serial_frame_pkg.sv
// Shared framing constants and state encodings for the serial frame link.
package serial_frame_pkg;

    localparam logic [7:0] HDR_0 = 8'h7B;
    localparam logic [7:0] HDR_1 = 8'h28;
    localparam logic [7:0] HDR_2 = 8'h31;
    localparam logic [7:0] HDR_3 = 8'h30;
    localparam logic [7:0] HDR_4 = 8'h32;
    localparam logic [7:0] HDR_5 = 8'h34;
    localparam logic [7:0] TRL_0 = 8'h29;
    localparam logic [7:0] TRL_1 = 8'h7D;

    localparam int unsigned HDR_LEN = 6;
    localparam int unsigned HIDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_DATA  = 3'd2,
        ST_TAIL1 = 3'd3,
        ST_TAIL2 = 3'd4
    } frame_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Header byte expected at a given header position.
    function automatic logic [7:0] hdr_byte(input logic [HIDX_W-1:0] idx);
        case (idx)
            3'd0:    hdr_byte = HDR_0;
            3'd1:    hdr_byte = HDR_1;
            3'd2:    hdr_byte = HDR_2;
            3'd3:    hdr_byte = HDR_3;
            3'd4:    hdr_byte = HDR_4;
            3'd5:    hdr_byte = HDR_5;
            default: hdr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer and mid-bit sampling.
module uart_rx_byte
    import serial_frame_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       byte_err
);

    localparam int unsigned BIT_CNT  = CLK_HZ / BAUD;
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          strobe_d, err_d;

    assign rx_s = sync_q[1];

    // Two-flop synchronizer plus delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rs232_rx};
            rx_prev_q <= sync_q[1];
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_data   <= '0;
            byte_strobe <= 1'b0;
            byte_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_data   <= data_d;
            byte_strobe <= strobe_d;
            byte_err    <= err_d;
        end
    end

    // Bit timing: verify start at half bit, then sample each bit centre.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = byte_data;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CW'(HALF_CNT - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(BIT_CNT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(BIT_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        strobe_d = 1'b1;
                        data_d   = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/serial_frame_recv.sv
// Serial frame receiver: header match, fixed-length payload, trailer check.
module serial_frame_recv
    import serial_frame_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PAYLOAD_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs232_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int unsigned PCW = $clog2(PAYLOAD_LEN + 1);

    logic [7:0]        b_data;
    logic              b_stb, b_err;
    frame_state_t      state_q, state_d;
    logic [HIDX_W-1:0] hidx_q, hidx_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic [7:0]        data_d;
    logic              valid_d, done_d, err_d;
    logic [15:0]       count_d;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs232_rx    (rs232_rx),
        .byte_data   (b_data),
        .byte_strobe (b_stb),
        .byte_err    (b_err)
    );

    // Frame state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hidx_q      <= '0;
            pcnt_q      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            hidx_q      <= hidx_d;
            pcnt_q      <= pcnt_d;
            rx_data     <= data_d;
            rx_valid    <= valid_d;
            frame_done  <= done_d;
            frame_err   <= err_d;
            busy        <= (state_d != ST_IDLE);
            frame_count <= count_d;
        end
    end

    // Frame parser: advances one step per received byte or byte error.
    always_comb begin
        state_d = state_q;
        hidx_d  = hidx_q;
        pcnt_d  = pcnt_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = frame_count;
        if (b_err) begin
            state_d = ST_IDLE;
            if (state_q inside {ST_DATA, ST_TAIL1, ST_TAIL2}) begin
                err_d = 1'b1;
            end
        end else if (b_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (b_data == HDR_0) begin
                        state_d = ST_HEAD;
                        hidx_d  = HIDX_W'(1);
                    end
                end
                ST_HEAD: begin
                    if (b_data == hdr_byte(hidx_q)) begin
                        if (hidx_q == HIDX_W'(HDR_LEN - 1)) begin
                            state_d = ST_DATA;
                            pcnt_d  = '0;
                        end else begin
                            hidx_d = hidx_q + HIDX_W'(1);
                        end
                    end else if (b_data == HDR_0) begin
                        hidx_d = HIDX_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    data_d  = b_data;
                    valid_d = 1'b1;
                    pcnt_d  = pcnt_q + PCW'(1);
                    if (pcnt_q == PCW'(PAYLOAD_LEN - 1)) begin
                        state_d = ST_TAIL1;
                    end
                end
                ST_TAIL1: begin
                    if (b_data == TRL_0) begin
                        state_d = ST_TAIL2;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_TAIL2: begin
                    state_d = ST_IDLE;
                    if (b_data == TRL_1) begin
                        done_d  = 1'b1;
                        count_d = frame_count + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_recv.sv
// Self-checking bench for serial_frame_recv with a frame-level expectation model.
module tb_serial_frame_recv;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned BAUD        = 125_000;
    localparam int unsigned PAYLOAD_LEN = 16;
    localparam int unsigned BIT_CNT     = CLK_HZ / BAUD;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rs232_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_strobe = 0;

    logic [7:0]  exp_q[$];
    int          exp_done  = 0;
    int          exp_err   = 0;
    logic [15:0] exp_count = 16'd0;

    bq_t hdr_std;
    bq_t hdr_alt;
    bq_t pl;

    serial_frame_recv #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .PAYLOAD_LEN (PAYLOAD_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs232_rx    (rs232_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: payload against scoreboard, strobe counting.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check_eq("payload_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("payload", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (frame_done || frame_err) begin
            check_eq("done_err_excl", 32'(frame_done & frame_err), 32'd0);
        end
        if (frame_done) n_done++;
        if (frame_err)  n_err++;
        if (dut.u_rx.byte_strobe) n_strobe++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rs232_rx = b;
        wait_clk(BIT_CNT);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        if (!stop_ok) send_bit(1'b1);
        rs232_rx = 1'b1;
        wait_clk(int'($urandom_range(0, 3)));
    endtask

    // Sends header, payload and trailer; a non-negative err_at sends that payload byte with a bad stop bit and stops.
    task automatic send_frame(input bq_t hdr, input bq_t p, input logic [7:0] t0,
                              input logic [7:0] t1, input int err_at);
        foreach (hdr[i]) send_byte(hdr[i], 1'b1);
        for (int i = 0; i < p.size(); i++) begin
            if (i == err_at) begin
                send_byte(p[i], 1'b0);
                return;
            end
            send_byte(p[i], 1'b1);
        end
        send_byte(t0, 1'b1);
        send_byte(t1, 1'b1);
    endtask

    // Expected outcome of a frame with a valid header, straight from the frame rules.
    task automatic expect_frame(input bq_t p, input logic [7:0] t0, input logic [7:0] t1,
                                input int err_at);
        int n;
        n = (err_at >= 0) ? err_at : p.size();
        for (int i = 0; i < n; i++) exp_q.push_back(p[i]);
        if (err_at >= 0) begin
            exp_err++;
        end else if (t0 == 8'h29 && t1 == 8'h7D) begin
            exp_done++;
            exp_count = exp_count + 16'd1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic run_frame(input bq_t hdr, input bq_t p, input logic [7:0] t0,
                             input logic [7:0] t1, input int err_at);
        expect_frame(p, t0, t1, err_at);
        send_frame(hdr, p, t0, t1, err_at);
        wait_clk(4);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"}, 32'(frame_count), 32'(exp_count));
        check_eq({tag, "_done"}, 32'(n_done), 32'(exp_done));
        check_eq({tag, "_err"}, 32'(n_err), 32'(exp_err));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic rand_payload();
        pl.delete();
        for (int i = 0; i < int'(PAYLOAD_LEN); i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_valid, s_strobe, s_err, kind, idx;
        logic [7:0] b, t1;

        hdr_std = '{8'h7B, 8'h28, 8'h31, 8'h30, 8'h32, 8'h34};
        hdr_alt = '{8'h7B, 8'h7B, 8'h28, 8'h31, 8'h30, 8'h32, 8'h34};
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        wait_clk(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        wait_clk(2 * BIT_CNT);

        // Stray bytes while idle are ignored.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h7B) b = 8'h7C;
            send_byte(b, 1'b1);
        end
        wait_clk(4);
        check_eq("noise_valid", 32'(n_valid), 32'd0);
        check_state("noise");

        // Good frame with counting payload.
        pl.delete();
        for (int i = 0; i < int'(PAYLOAD_LEN); i++) pl.push_back(8'(i % 256));
        run_frame(hdr_std, pl, 8'h29, 8'h7D, -1);
        check_eq("good_valid_cnt", 32'(n_valid), 32'(PAYLOAD_LEN));
        check_state("good");

        // Repeated 0x7B restarts the header.
        rand_payload();
        run_frame(hdr_alt, pl, 8'h29, 8'h7D, -1);
        check_state("alt_hdr");

        // Wrong final trailer byte.
        rand_payload();
        run_frame(hdr_std, pl, 8'h29, 8'h5D, -1);
        check_state("bad_tail");

        // Bad stop bit in the middle of the payload, then a clean frame with 0x7B/0x7D data.
        rand_payload();
        s_valid = n_valid;
        run_frame(hdr_std, pl, 8'h29, 8'h7D, 5);
        check_eq("stoperr_valid_cnt", 32'(n_valid - s_valid), 32'd5);
        check_state("stoperr");
        rand_payload();
        pl[0] = 8'h7B;
        pl[3] = 8'h7D;
        pl[PAYLOAD_LEN - 1] = 8'h7B;
        run_frame(hdr_std, pl, 8'h29, 8'h7D, -1);
        check_state("after_err");

        // Short low glitch on an idle line.
        s_valid  = n_valid;
        s_strobe = n_strobe;
        s_err    = n_err;
        rs232_rx = 1'b0;
        wait_clk(2);
        rs232_rx = 1'b1;
        wait_clk(3 * BIT_CNT);
        check_eq("glitch_strobe", 32'(n_strobe - s_strobe), 32'd0);
        check_eq("glitch_valid", 32'(n_valid - s_valid), 32'd0);
        check_eq("glitch_err", 32'(n_err - s_err), 32'd0);
        check_eq("glitch_busy", 32'(busy), 32'd0);

        // Reset in the middle of a payload byte.
        rand_payload();
        foreach (hdr_std[i]) send_byte(hdr_std[i], 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pl[i]);
            send_byte(pl[i], 1'b1);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        rs232_rx = 1'b0;
        wait_clk(BIT_CNT / 2);
        check_eq("busy_mid_frame", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        rs232_rx = 1'b1;
        wait_clk(3);
        check_outputs_zero("in_rst");
        exp_count = 16'd0;
        rst_n = 1'b1;
        wait_clk(2 * BIT_CNT);
        check_state("post_rst");
        rand_payload();
        run_frame(hdr_std, pl, 8'h29, 8'h7D, -1);
        check_eq("post_rst_count", 32'(frame_count), 32'd1);
        check_state("post_rst_frame");

        // Randomized mix of good, bad-trailer and byte-error frames.
        for (int f = 0; f < 6; f++) begin
            rand_payload();
            kind = int'($urandom_range(0, 2));
            idx  = -1;
            t1   = 8'h7D;
            if (kind == 1) begin
                t1 = 8'($urandom_range(0, 255));
                if (t1 == 8'h7D) t1 = 8'h7E;
            end else if (kind == 2) begin
                idx = int'($urandom_range(0, PAYLOAD_LEN - 1));
            end
            run_frame(hdr_std, pl, 8'h29, t1, idx);
            check_state("rand_frame");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
